// File: rtl/prefetch_pkg.sv
// rtl/prefetch_pkg.sv - shared types and sizes for the prefetch data queue
//   Provides the control-FSM opcode encoding, the per-slot flag record
//   and default queue geometry used by prefetch_data_queue and its RAM.
package prefetch_pkg;

  typedef enum logic [2:0] {
    PR_NOP       = 3'd0,
    PR_REQ_PREF  = 3'd1,
    PR_REQ_MGR   = 3'd2,
    PR_DATA_SUB  = 3'd3,
    PR_DATA_PROM = 3'd4
  } pr_op_e;

  typedef struct packed {
    logic first;
    logic last;
    logic data_valid;
    logic promised;
    logic drop;
  } slot_flags_t;

  localparam int PQ_ADDR_BITS       = 64;
  localparam int PQ_DATA_WIDTH      = 64;
  localparam int PQ_LOG_QUEUE_SIZE  = 6;
  localparam int PQ_BURST_LEN_WIDTH = 8;

endpackage

// File: rtl/pq_slot_ram.sv
// rtl/pq_slot_ram.sv - per-slot storage, one write port, one async read port
//   clk   : write clock
//   we    : write enable, waddr/wdata : write slot and value
//   raddr : read slot, rdata : combinational read value
module pq_slot_ram #(
  parameter int WIDTH     = 64,
  parameter int LOG_DEPTH = 6
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [LOG_DEPTH-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [LOG_DEPTH-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem_q [2**LOG_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/prefetch_data_queue.sv
// rtl/prefetch_data_queue.sv - circular beat buffer executing prefetcher opcodes
//   Inputs : clk, reset (async, active-high), pr_flush, pr_opCode,
//            pr_m_ar_addr / pr_m_ar_len (request), pr_isCleanup, m_r_data (DDR beat)
//   Outputs: pr_addrHit (combinational), pr_hasOutstanding, pr_reqCnt,
//            pr_almostFull, pr_r_valid / s_r_data / s_r_last (head beat),
//            protocol_err (sticky until reset or flush)
module prefetch_data_queue
  import prefetch_pkg::*;
#(
  parameter int ADDR_BITS       = PQ_ADDR_BITS,
  parameter int DATA_WIDTH      = PQ_DATA_WIDTH,
  parameter int LOG_QUEUE_SIZE  = PQ_LOG_QUEUE_SIZE,
  parameter int BURST_LEN_WIDTH = PQ_BURST_LEN_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pr_flush,
  input  logic [2:0]                 pr_opCode,
  input  logic [ADDR_BITS-1:0]       pr_m_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0] pr_m_ar_len,
  input  logic                       pr_isCleanup,
  input  logic [DATA_WIDTH-1:0]      m_r_data,
  output logic                       pr_addrHit,
  output logic                       pr_hasOutstanding,
  output logic [LOG_QUEUE_SIZE:0]    pr_reqCnt,
  output logic                       pr_almostFull,
  output logic                       pr_r_valid,
  output logic [DATA_WIDTH-1:0]      s_r_data,
  output logic                       s_r_last,
  output logic                       protocol_err
);

  localparam int N  = 1 << LOG_QUEUE_SIZE;
  localparam int PW = LOG_QUEUE_SIZE + 1;
  // Wide enough for len+1 (up to 2^BURST_LEN_WIDTH) and for the free count.
  localparam int CW = ((PW > BURST_LEN_WIDTH + 1) ? PW : BURST_LEN_WIDTH + 1) + 1;

  // Pointers carry one wrap bit above the slot index so full and empty differ.
  typedef logic [PW-1:0]             ptr_t;
  typedef logic [LOG_QUEUE_SIZE-1:0] idx_t;
  typedef logic [CW-1:0]             cnt_t;

  ptr_t        tail_q, tail_d, wptr_q, wptr_d, pptr_q, pptr_d, head_q, head_d;
  slot_flags_t flags_q [N];
  slot_flags_t flags_d [N];
  logic        err_q, err_d;

  logic                  data_we, addr_we;
  logic [ADDR_BITS-1:0]  pptr_addr;
  ptr_t                  used, pend, blen;
  cnt_t                  need, free_slots;
  logic                  hit, found, pop, alloc, is_mgr, r_valid;
  slot_flags_t           head_f;
  pr_op_e                op;

  function automatic idx_t slot_at(input ptr_t base, input int off);
    return base[LOG_QUEUE_SIZE-1:0] + idx_t'(off);
  endfunction

  pq_slot_ram #(.WIDTH(DATA_WIDTH), .LOG_DEPTH(LOG_QUEUE_SIZE)) u_data_ram (
    .clk   (clk),
    .we    (data_we),
    .waddr (wptr_q[LOG_QUEUE_SIZE-1:0]),
    .wdata (m_r_data),
    .raddr (head_q[LOG_QUEUE_SIZE-1:0]),
    .rdata (s_r_data)
  );

  // Only the first slot of a burst carries a meaningful address.
  pq_slot_ram #(.WIDTH(ADDR_BITS), .LOG_DEPTH(LOG_QUEUE_SIZE)) u_addr_ram (
    .clk   (clk),
    .we    (addr_we),
    .waddr (tail_q[LOG_QUEUE_SIZE-1:0]),
    .wdata (pr_m_ar_addr),
    .raddr (pptr_q[LOG_QUEUE_SIZE-1:0]),
    .rdata (pptr_addr)
  );

  assign used       = tail_q - head_q;
  assign pend       = tail_q - pptr_q;
  assign need       = cnt_t'(pr_m_ar_len) + cnt_t'(1);
  assign free_slots = cnt_t'(N) - cnt_t'(used);
  assign head_f     = flags_q[head_q[LOG_QUEUE_SIZE-1:0]];
  assign r_valid    = head_f.data_valid & head_f.promised & ~head_f.drop;

  // pptr can land mid-burst after a cleanup discard; requiring 'first'
  // keeps such a leftover tail from matching a new request.
  assign hit = (pptr_q != tail_q) && (pptr_addr == pr_m_ar_addr) &&
               flags_q[pptr_q[LOG_QUEUE_SIZE-1:0]].first &&
               !flags_q[pptr_q[LOG_QUEUE_SIZE-1:0]].drop;

  always_comb begin
    tail_d  = tail_q;
    wptr_d  = wptr_q;
    pptr_d  = pptr_q;
    head_d  = head_q;
    flags_d = flags_q;
    err_d   = err_q;
    data_we = 1'b0;
    addr_we = 1'b0;
    pop     = 1'b0;
    alloc   = 1'b0;
    is_mgr  = 1'b0;
    blen    = '0;
    found   = 1'b0;
    op      = pr_op_e'(pr_opCode);

    // Length of the burst starting at pptr, bounded by the allocated region.
    for (int k = 0; k < N; k++) begin
      if (!found && (ptr_t'(k) < pend)) begin
        blen = blen + ptr_t'(1);
        if (flags_q[slot_at(pptr_q, k)].last) begin
          found = 1'b1;
        end
      end
    end

    // Explicit promise pop takes precedence over auto-discard of the head.
    if (op == PR_DATA_PROM) begin
      if (r_valid) pop = 1'b1;
      else         err_d = 1'b1;
    end else if (head_f.data_valid &&
                 (head_f.drop || (pr_isCleanup && !head_f.promised))) begin
      pop = 1'b1;
    end

    case (op)
      PR_REQ_PREF: alloc = 1'b1;
      PR_REQ_MGR: begin
        if (hit) begin
          for (int k = 0; k < N; k++) begin
            if (ptr_t'(k) < blen) flags_d[slot_at(pptr_q, k)].promised = 1'b1;
          end
          pptr_d = pptr_q + blen;
        end else begin
          alloc  = 1'b1;
          is_mgr = 1'b1;
        end
      end
      PR_DATA_SUB: begin
        if (wptr_q == tail_q) begin
          err_d = 1'b1;
        end else begin
          flags_d[wptr_q[LOG_QUEUE_SIZE-1:0]].data_valid = 1'b1;
          data_we = 1'b1;
          wptr_d  = wptr_q + ptr_t'(1);
        end
      end
      default: ;
    endcase

    if (alloc) begin
      if (need > free_slots) begin
        err_d = 1'b1;
      end else begin
        if (is_mgr) begin
          // The manager skipped past everything still unpromised.
          for (int k = 0; k < N; k++) begin
            if ((ptr_t'(k) < pend) && !flags_q[slot_at(pptr_q, k)].promised)
              flags_d[slot_at(pptr_q, k)].drop = 1'b1;
          end
          pptr_d = tail_q + ptr_t'(need);
        end
        for (int k = 0; k < N; k++) begin
          if (cnt_t'(k) < need) begin
            flags_d[slot_at(tail_q, k)].first      = (k == 0);
            flags_d[slot_at(tail_q, k)].last       = (cnt_t'(k) == need - cnt_t'(1));
            flags_d[slot_at(tail_q, k)].data_valid = 1'b0;
            flags_d[slot_at(tail_q, k)].promised   = is_mgr;
            flags_d[slot_at(tail_q, k)].drop       = 1'b0;
          end
        end
        addr_we = 1'b1;
        tail_d  = tail_q + ptr_t'(need);
      end
    end

    if (pop) begin
      flags_d[head_q[LOG_QUEUE_SIZE-1:0]] = '0;
      head_d = head_q + ptr_t'(1);
      // Discarding the slot pptr points at drags pptr along with head.
      if ((head_q == pptr_q) && (pptr_d == pptr_q)) pptr_d = pptr_q + ptr_t'(1);
    end

    if (pr_flush) begin
      tail_d  = '0;
      wptr_d  = '0;
      pptr_d  = '0;
      head_d  = '0;
      err_d   = 1'b0;
      data_we = 1'b0;
      addr_we = 1'b0;
      for (int i = 0; i < N; i++) flags_d[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tail_q <= '0;
      wptr_q <= '0;
      pptr_q <= '0;
      head_q <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < N; i++) flags_q[i] <= '0;
    end else begin
      tail_q  <= tail_d;
      wptr_q  <= wptr_d;
      pptr_q  <= pptr_d;
      head_q  <= head_d;
      err_q   <= err_d;
      flags_q <= flags_d;
    end
  end

  assign pr_addrHit        = hit;
  assign pr_hasOutstanding = (wptr_q != tail_q);
  assign pr_reqCnt         = used;
  assign pr_almostFull     = (used > ptr_t'(N / 2));
  assign pr_r_valid        = r_valid;
  assign s_r_last          = head_f.last;
  assign protocol_err      = err_q;

endmodule

// File: tb/tb_prefetch_data_queue.sv
// tb/tb_prefetch_data_queue.sv - randomized bench with a slot-queue reference model
module tb_prefetch_data_queue;
  import prefetch_pkg::*;

  localparam int QN = 64;

  logic        clk = 1'b0;
  logic        reset, pr_flush, pr_isCleanup;
  logic [2:0]  pr_opCode;
  logic [63:0] pr_m_ar_addr, m_r_data;
  logic [7:0]  pr_m_ar_len;
  logic        pr_addrHit, pr_hasOutstanding, pr_almostFull, pr_r_valid, s_r_last, protocol_err;
  logic [6:0]  pr_reqCnt;
  logic [63:0] s_r_data;

  always #5 clk = ~clk;

  prefetch_data_queue dut (
    .clk(clk), .reset(reset), .pr_flush(pr_flush), .pr_opCode(pr_opCode),
    .pr_m_ar_addr(pr_m_ar_addr), .pr_m_ar_len(pr_m_ar_len), .pr_isCleanup(pr_isCleanup),
    .m_r_data(m_r_data), .pr_addrHit(pr_addrHit), .pr_hasOutstanding(pr_hasOutstanding),
    .pr_reqCnt(pr_reqCnt), .pr_almostFull(pr_almostFull), .pr_r_valid(pr_r_valid),
    .s_r_data(s_r_data), .s_r_last(s_r_last), .protocol_err(protocol_err)
  );

  // Model: a queue of occupied slots, element 0 is the head.
  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    bit          first, last, dv, prom, drop;
  } mslot_t;

  mslot_t mq[$];
  int     widx;   // index of the next slot awaiting data
  int     pidx;   // index of the oldest unpromised burst
  bit     merr;
  int     n_vec = 0;
  int     n_bad = 0;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit m_rvalid();
    return mq.size() > 0 && mq[0].dv && mq[0].prom && !mq[0].drop;
  endfunction

  function automatic bit m_hit(input logic [63:0] a);
    return pidx < mq.size() && mq[pidx].first && !mq[pidx].drop && mq[pidx].addr == a;
  endfunction

  task automatic m_clear();
    mq.delete();
    widx = 0;
    pidx = 0;
    merr = 0;
  endtask

  task automatic m_alloc(input logic [63:0] a, input int need, input bit mgr);
    mslot_t s;
    if (need > QN - mq.size()) begin
      merr = 1;
      return;
    end
    if (mgr) for (int i = pidx; i < mq.size(); i++) if (!mq[i].prom) mq[i].drop = 1;
    for (int k = 0; k < need; k++) begin
      s = '{addr: a, data: 64'h0, first: (k == 0), last: (k == need - 1), dv: 0, prom: mgr, drop: 0};
      mq.push_back(s);
    end
    if (mgr) pidx = mq.size();
  endtask

  task automatic m_apply(input logic [2:0] op, input logic [63:0] a, input logic [7:0] len,
                         input logic [63:0] d, input bit cln, input bit hit);
    bit pop = 0;
    bit was_last;
    if (op == 3'd4) begin
      if (m_rvalid()) pop = 1;
      else merr = 1;
    end else if (mq.size() > 0 && mq[0].dv && (mq[0].drop || (cln && !mq[0].prom))) begin
      pop = 1;
    end
    case (op)
      3'd1: m_alloc(a, int'(len) + 1, 0);
      3'd2: begin
        if (hit) begin
          do begin
            mq[pidx].prom = 1;
            was_last = mq[pidx].last;
            pidx++;
          end while (!was_last && pidx < mq.size());
        end else begin
          m_alloc(a, int'(len) + 1, 1);
        end
      end
      3'd3: begin
        if (widx == mq.size()) merr = 1;
        else begin
          mq[widx].dv = 1;
          mq[widx].data = d;
          widx++;
        end
      end
      default: ;
    endcase
    if (pop) begin
      void'(mq.pop_front());
      widx--;
      if (pidx > 0) pidx--;
    end
  endtask

  task automatic check_outputs();
    int sz = mq.size();
    chk_eq("req_cnt", 64'(pr_reqCnt), 64'(sz));
    chk_eq("has_outstanding", 64'(pr_hasOutstanding), 64'(widx < sz));
    chk_eq("almost_full", 64'(pr_almostFull), 64'((QN - sz) < QN / 2));
    chk_eq("r_valid", 64'(pr_r_valid), 64'(m_rvalid()));
    chk_eq("r_last", 64'(s_r_last), 64'((sz > 0) ? mq[0].last : 1'b0));
    if (m_rvalid()) chk_eq("r_data", s_r_data, mq[0].data);
    chk_eq("protocol_err", 64'(protocol_err), 64'(merr));
  endtask

  // Drive one cycle of inputs, check the combinational hit, clock, check state.
  task automatic step(input logic [2:0] op, input logic [63:0] a, input logic [7:0] len,
                      input logic [63:0] d, input bit cln, input bit fl);
    bit hit;
    pr_opCode    = op;
    pr_m_ar_addr = a;
    pr_m_ar_len  = len;
    m_r_data     = d;
    pr_isCleanup = cln;
    pr_flush     = fl;
    #3;
    hit = m_hit(a);
    chk_eq("addr_hit", 64'(pr_addrHit), 64'(hit));
    @(posedge clk);
    if (fl) m_clear();
    else m_apply(op, a, len, d, cln, hit);
    #1;
    check_outputs();
  endtask

  localparam logic [63:0] DA = 64'hAAAA_0000_1111_2222;
  localparam logic [63:0] DB = 64'hBBBB_3333_4444_5555;

  initial begin
    logic [2:0]  op;
    logic [63:0] a, d;
    logic [7:0]  len;
    bit          cln, fl;

    reset = 1'b0; pr_flush = 1'b0; pr_isCleanup = 1'b0; pr_opCode = 3'd0;
    pr_m_ar_addr = '0; pr_m_ar_len = '0; m_r_data = '0;
    m_clear();
    #1 reset = 1'b1;
    #2;
    check_outputs();
    chk_eq("reset_hit", 64'(pr_addrHit), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Prefetch a two-beat burst, fill it, then let the manager claim it.
    step(PR_REQ_PREF, 64'h1000, 8'd1, 64'h0, 0, 0);
    step(PR_DATA_SUB, 64'h0, 8'd0, DA, 0, 0);
    chk_eq("t1_outstanding", 64'(pr_hasOutstanding), 64'd1);
    step(PR_DATA_SUB, 64'h0, 8'd0, DB, 0, 0);
    step(PR_REQ_MGR, 64'h1000, 8'd1, 64'h0, 0, 0);
    chk_eq("t2_data_a", s_r_data, DA);
    step(PR_DATA_PROM, 64'h0, 8'd0, 64'h0, 0, 0);
    chk_eq("t2_last_b", 64'(s_r_last), 64'd1);
    step(PR_DATA_PROM, 64'h0, 8'd0, 64'h0, 0, 0);

    // Manager miss drops the stale prefetch, which then self-discards.
    step(PR_REQ_PREF, 64'h2000, 8'd0, 64'h0, 0, 0);
    step(PR_REQ_MGR, 64'h3000, 8'd0, 64'h0, 0, 0);
    chk_eq("t3_cnt", 64'(pr_reqCnt), 64'd2);
    step(PR_DATA_SUB, 64'h0, 8'd0, 64'h2222, 0, 0);
    step(PR_DATA_SUB, 64'h0, 8'd0, 64'h3333, 0, 0);
    chk_eq("t3_data", s_r_data, 64'h3333);
    step(PR_DATA_PROM, 64'h0, 8'd0, 64'h0, 0, 0);

    // Fill to 63 slots, then overflow.
    step(PR_REQ_PREF, 64'h4000, 8'd31, 64'h0, 0, 0);
    step(PR_REQ_PREF, 64'h5000, 8'd30, 64'h0, 0, 0);
    step(PR_REQ_PREF, 64'h6000, 8'd1, 64'h0, 0, 0);
    chk_eq("t4_err", 64'(protocol_err), 64'd1);
    chk_eq("t4_cnt", 64'(pr_reqCnt), 64'd63);

    // Protocol errors are sticky until flush; flush beats a same-cycle op.
    step(PR_NOP, 64'h0, 8'd0, 64'h0, 0, 1);
    step(PR_DATA_SUB, 64'h0, 8'd0, 64'h1, 0, 0);
    step(PR_NOP, 64'h0, 8'd0, 64'h0, 0, 0);
    step(PR_NOP, 64'h0, 8'd0, 64'h0, 0, 1);
    step(PR_DATA_PROM, 64'h0, 8'd0, 64'h0, 0, 0);
    step(PR_REQ_PREF, 64'h7000, 8'd3, 64'h0, 0, 1);
    chk_eq("t5_flush_cnt", 64'(pr_reqCnt), 64'd0);

    // Cleanup discards filled unpromised slots.
    step(PR_REQ_PREF, 64'h8000, 8'd0, 64'h0, 0, 0);
    step(PR_DATA_SUB, 64'h0, 8'd0, 64'h8888, 1, 0);
    step(PR_NOP, 64'h0, 8'd0, 64'h0, 1, 0);
    chk_eq("t6_cnt", 64'(pr_reqCnt), 64'd0);

    // Random traffic; the pointers wrap many times.
    for (int n = 0; n < 4000; n++) begin
      fl  = ($urandom_range(0, 149) == 0);
      cln = ($urandom_range(0, 9) == 0);
      len = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 3));
      d   = {$urandom, $urandom};
      if (pidx < mq.size() && $urandom_range(0, 1) == 1) a = mq[pidx].addr;
      else a = 64'h1000 * 64'($urandom_range(1, 4));
      if (m_rvalid() && $urandom_range(0, 1) == 1) op = 3'd4;
      else case ($urandom_range(0, 9))
        0:       op = 3'd0;
        1:       op = 3'd1;
        2, 3:    op = 3'd2;
        4:       op = 3'd4;
        9:       op = 3'($urandom_range(5, 7));
        default: op = 3'd3;
      endcase
      step(op, a, len, d, cln, fl);
    end

    // Asynchronous reset in the middle of traffic clears state at once.
    step(PR_REQ_PREF, 64'h9000, 8'd3, 64'h0, 0, 0);
    step(PR_DATA_SUB, 64'h0, 8'd0, 64'h9999, 0, 0);
    #2 reset = 1'b1;
    #1;
    m_clear();
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
